// File: rtl/hps_event_reporter.sv
// Fabric-to-HPS event reporter: captures key, delay and pause events into a small
// FIFO and exposes them with live status through a 4-word Avalon-MM slave plus an irq.
module hps_event_reporter #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_faster,
  input  logic        key_slower,
  input  logic [3:0]  delay,
  input  logic [7:0]  led,
  input  logic        pause,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [3:0]       delay_q, delay_d;
  logic             pause_q, pause_d;
  logic             primed_q, primed_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       hold_delay_q, hold_delay_d;
  logic             hold_pause_q, hold_pause_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic [PW-1:0] fill;
  logic          empty, full;
  logic          rd_evt, wr_ctl, wr_cnt, flush;
  logic          push_req, push, pop, drop;
  logic [1:0]    sel_idx;
  logic [3:0]    sel_mask, pend_eff, fire, set_new;
  logic [7:0]    push_code;
  logic [31:0]   status;
  logic          unused_wdata;

  assign fill         = wr_ptr_q - rd_ptr_q;
  assign empty        = (fill == '0);
  assign full         = (fill == PW'(FIFO_DEPTH));
  assign irq          = irq_en_q & ~empty;
  assign readdata     = readdata_q;
  assign unused_wdata = ^writedata[31:3];

  always_comb begin
    rd_evt = read && (address == 2'd1);
    wr_ctl = write && (address == 2'd2);
    wr_cnt = write && (address == 2'd3);
    flush  = wr_ctl && writedata[2];

    // Fixed priority: faster, slower, delay, pause
    push_req = |pend_q;
    if (pend_q[0])      sel_idx = 2'd0;
    else if (pend_q[1]) sel_idx = 2'd1;
    else if (pend_q[2]) sel_idx = 2'd2;
    else                sel_idx = 2'd3;
    sel_mask = push_req ? (4'b0001 << sel_idx) : 4'b0000;

    case (sel_idx)
      2'd0:    push_code = 8'h00;
      2'd1:    push_code = 8'h40;
      2'd2:    push_code = {4'b1000, hold_delay_q};
      default: push_code = {7'b1100000, hold_pause_q};
    endcase

    pop  = rd_evt && !empty && !flush;
    push = push_req && (!full || pop) && !flush;
    drop = push_req && full && !pop && !flush;

    fire[0] = key_faster;
    fire[1] = key_slower;
    fire[2] = primed_q && (delay != delay_q);
    fire[3] = primed_q && (pause != pause_q);

    // A source being pushed this cycle is free to accept a fresh event
    pend_eff = pend_q & ~sel_mask;
    set_new  = fire & ~pend_eff;
    pend_d   = flush ? 4'b0000 : (pend_eff | fire);

    hold_delay_d = set_new[2] ? delay : hold_delay_q;
    hold_pause_d = set_new[3] ? pause : hold_pause_q;

    overflow_d = overflow_q;
    if (wr_ctl && writedata[1]) overflow_d = 1'b0;
    if ((|(fire & pend_eff)) || drop) overflow_d = 1'b1;

    irq_en_d  = wr_ctl ? writedata[0] : irq_en_q;
    evt_cnt_d = wr_cnt ? '0 : evt_cnt_q + CNT_W'(push);
    wr_ptr_d  = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + PW'(pop);

    delay_d  = delay;
    pause_d  = pause;
    primed_d = 1'b1;

    status = {3'b000, pause, delay, led, 4'b0000, irq_en_q, overflow_q, full, empty,
              3'b000, 5'(fill)};

    readdata_d = readdata_q;
    if (read) begin
      case (address)
        2'd0:    readdata_d = status;
        2'd1:    readdata_d = empty ? 32'h0 : {1'b1, 23'b0, mem_q[rd_ptr_q[AW-1:0]]};
        2'd2:    readdata_d = {31'b0, irq_en_q};
        default: readdata_d = 32'(evt_cnt_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_q    <= '0;
      pause_q    <= 1'b0;
      primed_q   <= 1'b0;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      evt_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      delay_q    <= delay_d;
      pause_q    <= pause_d;
      primed_q   <= primed_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      evt_cnt_q  <= evt_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  // Payload holding registers and FIFO storage carry data only
  always_ff @(posedge clk) begin
    hold_delay_q <= hold_delay_d;
    hold_pause_q <= hold_pause_d;
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_code;
  end

endmodule

// File: tb/tb_hps_event_reporter.sv
// Bench for hps_event_reporter: directed scenarios plus randomized traffic against
// a queue-based reference model of the event reporter.
module tb_hps_event_reporter;
  logic        clk = 1'b0;
  logic        reset;
  logic        key_faster, key_slower, pause, read, write;
  logic [3:0]  delay;
  logic [7:0]  led;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  hps_event_reporter #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .key_faster(key_faster), .key_slower(key_slower),
    .delay(delay), .led(led), .pause(pause), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mq [$];
  bit   [3:0]  m_pend;
  logic [3:0]  m_hold [4];
  bit          m_primed, m_sp, m_ovf, m_irqen;
  logic [3:0]  m_sd;
  int          m_cnt;
  logic [31:0] m_rd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic bit m_irq();
    return m_irqen && (mq.size() > 0);
  endfunction

  function automatic logic [31:0] m_status();
    logic [4:0] f;
    f = 5'(mq.size());
    return {3'b000, pause, delay, led, 4'b0000, m_irqen, m_ovf, (mq.size() == 16),
            (mq.size() == 0), 3'b000, f};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend = '0;
    m_primed = 0; m_sd = '0; m_sp = 0;
    m_ovf = 0; m_irqen = 0; m_cnt = 0; m_rd = '0;
    for (int i = 0; i < 4; i++) m_hold[i] = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit flush, pop, do_push;
    int sel;
    logic [7:0] code;
    bit [3:0] fire;
    logic [3:0] pay [4];
    if (read) begin
      case (address)
        2'd0: m_rd = m_status();
        2'd1: m_rd = (mq.size() > 0) ? {1'b1, 23'b0, mq[0]} : 32'h0;
        2'd2: m_rd = {31'b0, m_irqen};
        default: m_rd = 32'(m_cnt);
      endcase
    end
    flush = write && (address == 2'd2) && writedata[2];
    if (write && (address == 2'd2) && writedata[1]) m_ovf = 0;
    pop = read && (address == 2'd1) && (mq.size() > 0) && !flush;
    sel = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
    do_push = 0;
    code = '0;
    if (sel >= 0) begin
      m_pend[sel] = 0;
      if (!flush) begin
        if (mq.size() < 16 || pop) begin
          do_push = 1;
          code = {2'(sel), 2'b00, m_hold[sel]};
          m_cnt = (m_cnt + 1) % 65536;
        end else m_ovf = 1;
      end
    end
    fire = {m_primed && (pause !== m_sp), m_primed && (delay !== m_sd), key_slower, key_faster};
    pay[0] = 4'h0; pay[1] = 4'h0; pay[2] = delay; pay[3] = {3'b000, pause};
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        if (m_pend[i]) m_ovf = 1;
        else begin
          m_pend[i] = 1;
          m_hold[i] = pay[i];
        end
      end
    end
    if (flush) begin
      m_pend = '0;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(code);
    end
    if (write && (address == 2'd3)) m_cnt = 0;
    if (write && (address == 2'd2)) m_irqen = writedata[0];
    m_sd = delay; m_sp = pause; m_primed = 1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("irq", {31'b0, irq}, {31'b0, m_irq()});
    check("readdata", readdata, m_rd);
    key_faster = 0; key_slower = 0; read = 0; write = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1;
    step();
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; write = 1;
    step();
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_evt [4];
    exp_evt[0] = 32'h8000_0000; exp_evt[1] = 32'h8000_0040;
    exp_evt[2] = 32'h8000_0086; exp_evt[3] = 32'h8000_00C0;

    reset = 1; key_faster = 0; key_slower = 0; delay = 4'd5; pause = 1; led = 8'hA5;
    address = 0; read = 0; write = 0; writedata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 0;
    repeat (3) step();
    rd(2'd0, d);
    check("boot_status", d, 32'h15A5_0100);

    // Single faster-key event with interrupt enabled
    wr(2'd2, 32'h1);
    key_faster = 1; step();
    check("irq_n1", {31'b0, irq}, 32'h0);
    step();
    check("irq_n2", {31'b0, irq}, 32'h1);
    rd(2'd1, d);
    check("evt_faster", d, 32'h8000_0000);
    check("irq_after_pop", {31'b0, irq}, 32'h0);
    rd(2'd3, d);
    check("count_one", d, 32'd1);

    // All four sources in one cycle
    key_faster = 1; key_slower = 1; delay = 4'd6; pause = 0;
    step();
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      rd(2'd1, d);
      check($sformatf("evt_prio%0d", i), d, exp_evt[i]);
    end
    rd(2'd1, d);
    check("evt_empty", d, 32'h0);

    // Overfill, then clear overflow
    wr(2'd3, 32'h0);
    repeat (17) begin key_faster = 1; step(); end
    repeat (3) step();
    rd(2'd0, d);
    check("full_status", {20'b0, d[11:0]}, 32'hE10);
    rd(2'd3, d);
    check("count_16", d, 32'd16);
    wr(2'd2, 32'h2);
    rd(2'd0, d);
    check("ovf_cleared", {22'b0, d[9:0]} | {21'b0, d[10], 10'b0}, 32'h210);

    // Push and pop in the same cycle while full
    key_faster = 1; step();
    address = 2'd1; read = 1; step();
    rd(2'd0, d);
    check("full_push_pop", {21'b0, d[10:0]}, 32'h210);
    wr(2'd2, 32'h4);
    rd(2'd0, d);
    check("flush_status", {22'b0, d[9:0]}, 32'h100);

    // Reset with events queued
    wr(2'd2, 32'h1);
    repeat (3) begin key_faster = 1; step(); end
    repeat (2) step();
    check("irq_pre_reset", {31'b0, irq}, 32'h1);
    rd(2'd0, d);
    reset = 1;
    #1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    step();
    rd(2'd0, d);
    check("post_rst_empty", {22'b0, d[9:0]}, 32'h100);
    rd(2'd3, d);
    check("post_rst_count", d, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      key_faster = ($urandom_range(0, 3) == 0);
      key_slower = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) delay = 4'($urandom);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      led = 8'($urandom);
      address = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom);
      read = ($urandom_range(0, 2) != 0);
      write = ($urandom_range(0, 11) == 0);
      writedata = $urandom;
      if ($urandom_range(0, 7) != 0) writedata[2] = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
